// File: rtl/vga_fb_arbiter_pkg.sv
// Shared types and constants for the frame-buffer arbiter: sweep FSM states,
// video geometry and default bus widths.
package vga_fb_pkg;

  localparam int VIDEO_W        = 560;
  localparam int VIDEO_H        = 420;
  localparam int VIDEO_FB_WORDS = VIDEO_W * VIDEO_H;

  localparam int DEFAULT_ADDR_W = 19;
  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DRAIN = 2'd2
  } fb_state_t;

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Display fetch, host write, clear control and RAM port of the arbiter.
// Host write channel: a beat transfers on a rising edge where iWR_VALID && oWR_READY.
interface vga_fb_arbiter_if #(
  parameter int ADDR_W = vga_fb_pkg::DEFAULT_ADDR_W,
  parameter int DATA_W = vga_fb_pkg::DEFAULT_DATA_W
);
  logic              iDISP_REQ;
  logic [ADDR_W-1:0] iDISP_ADDR;
  logic [DATA_W-1:0] oDISP_DATA;
  logic              oDISP_VALID;
  logic              iWR_VALID;
  logic [ADDR_W-1:0] iWR_ADDR;
  logic [DATA_W-1:0] iWR_DATA;
  logic              oWR_READY;
  logic              iCLR_REQ;
  logic [DATA_W-1:0] iCLR_VAL;
  logic              oCLR_BUSY;
  logic [ADDR_W-1:0] oRAM_ADDR;
  logic [DATA_W-1:0] oRAM_WDATA;
  logic              oRAM_WE;
  logic [DATA_W-1:0] iRAM_Q;

  modport slave (
    input  iDISP_REQ, iDISP_ADDR, iWR_VALID, iWR_ADDR, iWR_DATA,
           iCLR_REQ, iCLR_VAL, iRAM_Q,
    output oDISP_DATA, oDISP_VALID, oWR_READY, oCLR_BUSY,
           oRAM_ADDR, oRAM_WDATA, oRAM_WE
  );

  modport master (
    output iDISP_REQ, iDISP_ADDR, iWR_VALID, iWR_ADDR, iWR_DATA,
           iCLR_REQ, iCLR_VAL, iRAM_Q,
    input  oDISP_DATA, oDISP_VALID, oWR_READY, oCLR_BUSY,
           oRAM_ADDR, oRAM_WDATA, oRAM_WE
  );
endinterface

// File: rtl/vga_fb_arbiter_fb_wr_fifo.sv
// Host write buffer holding {addr,data}; ready is a flop that tracks
// "not full" for the following cycle.
module fb_wr_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 27
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic                     ready,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   cnt_nxt;

  assign cnt_nxt = count + (PW+1)'(push) - (PW+1)'(pop);
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= cnt_nxt;
      ready <= (cnt_nxt != (PW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: display fetch first, then clear sweep,
// then buffered host writes. RAM port is combinational from this cycle's grant.
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int ADDR_W     = DEFAULT_ADDR_W,
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int FB_WORDS   = VIDEO_FB_WORDS,
  parameter int FIFO_DEPTH = 8,
  parameter int RD_LAT     = 1
) (
  input  logic                        iVGA_CLK,
  input  logic                        iRST_n,
  vga_fb_arbiter_if.slave             fb,
  output fb_state_t                   dbg_state,
  output logic [$clog2(FIFO_DEPTH):0] dbg_fifo_count
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WORDS - 1);

  fb_state_t         state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0] clr_val_q, clr_val_d;
  logic [ADDR_W-1:0] last_addr_q;
  logic [RD_LAT-1:0] vld_q;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;

  logic              push, pop, empty, wr_ready;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  assign push = fb.iWR_VALID && wr_ready;

  fb_wr_fifo #(.DEPTH(FIFO_DEPTH), .W(ADDR_W + DATA_W)) u_fifo (
    .clk   (iVGA_CLK),
    .rst_n (iRST_n),
    .push  (push),
    .pop   (pop),
    .din   ({fb.iWR_ADDR, fb.iWR_DATA}),
    .dout  ({head_addr, head_data}),
    .empty (empty),
    .ready (wr_ready),
    .count (dbg_fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_val_d = clr_val_q;
    pop       = 1'b0;
    ram_addr  = last_addr_q;
    ram_wdata = '0;
    ram_we    = 1'b0;

    // Host writes stay parked during the sweep so they land on top of it.
    if (fb.iDISP_REQ) begin
      ram_addr = fb.iDISP_ADDR;
    end else if (state_q == CLEAR) begin
      ram_addr  = clr_cnt_q;
      ram_wdata = clr_val_q;
      ram_we    = 1'b1;
    end else if (!empty) begin
      ram_addr  = head_addr;
      ram_wdata = head_data;
      ram_we    = 1'b1;
      pop       = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (fb.iCLR_REQ) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
          clr_val_d = fb.iCLR_VAL;
        end
      end
      CLEAR: begin
        if (!fb.iDISP_REQ) begin
          if (clr_cnt_q == LAST_ADDR) state_d = DRAIN;
          else clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (empty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q     <= IDLE;
      clr_cnt_q   <= '0;
      clr_val_q   <= '0;
      last_addr_q <= '0;
      vld_q       <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      clr_val_q   <= clr_val_d;
      last_addr_q <= ram_addr;
      vld_q[0]    <= fb.iDISP_REQ;
      for (int i = 1; i < RD_LAT; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  assign fb.oRAM_ADDR   = ram_addr;
  assign fb.oRAM_WDATA  = ram_wdata;
  assign fb.oRAM_WE     = ram_we;
  assign fb.oDISP_VALID = vld_q[RD_LAT-1];
  assign fb.oDISP_DATA  = vld_q[RD_LAT-1] ? fb.iRAM_Q : '0;
  assign fb.oWR_READY   = wr_ready;
  assign fb.oCLR_BUSY   = (state_q != IDLE);
  assign dbg_state      = state_q;
endmodule
